peri_apb_bridge_n: RTL

Parametrised single-clock AXI3-to-APB bridge, the next generation of the peripheral bridge: one AXI3 slave port fanned out to NSLV APB slaves by address decode. Unlike the previous bridge, it supports multi-beat bursts split into APB transfers, reports DECERR on decode misses, and aborts hung APB accesses with a timeout. It sits between the peripheral interconnect port and the peripheral cluster (WDT, PMU, OTP and others), all running on the AXI clock.

---
 rtl/peri_apb_bridge_n.sv | 298 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/peri_apb_bridge_n.sv
// AXI3 slave to NSLV-way APB bridge: one transaction in flight, bursts split into
// APB beats, DECERR on decode miss, SLVERR plus IRQ pulse on an APB access timeout.
module peri_apb_bridge_n #(
    parameter int                ID_W      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                NSLV      = 4,
    parameter int                SLV_AW    = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h4000_0000),
    parameter int                TIMEOUT   = 256
) (
    input  logic                 i_aclk,
    input  logic                 i_aresetn,
    input  logic [ID_W-1:0]      i_peri_awid,
    input  logic [ADDR_W-1:0]    i_peri_awaddr,
    input  logic [3:0]           i_peri_awlen,
    input  logic [1:0]           i_peri_awburst,
    input  logic [2:0]           i_peri_awprot,
    input  logic                 i_peri_awvalid,
    output logic                 o_peri_awready,
    input  logic [31:0]          i_peri_wdata,
    input  logic [3:0]           i_peri_wstrb,
    input  logic                 i_peri_wlast,
    input  logic                 i_peri_wvalid,
    output logic                 o_peri_wready,
    output logic [ID_W-1:0]      o_peri_bid,
    output logic [1:0]           o_peri_bresp,
    output logic                 o_peri_bvalid,
    input  logic                 i_peri_bready,
    input  logic [ID_W-1:0]      i_peri_arid,
    input  logic [ADDR_W-1:0]    i_peri_araddr,
    input  logic [3:0]           i_peri_arlen,
    input  logic [1:0]           i_peri_arburst,
    input  logic [2:0]           i_peri_arprot,
    input  logic                 i_peri_arvalid,
    output logic                 o_peri_arready,
    output logic [ID_W-1:0]      o_peri_rid,
    output logic [31:0]          o_peri_rdata,
    output logic [1:0]           o_peri_rresp,
    output logic                 o_peri_rlast,
    output logic                 o_peri_rvalid,
    input  logic                 i_peri_rready,
    output logic [NSLV-1:0]      o_psel,
    output logic                 o_penable,
    output logic [ADDR_W-1:0]    o_paddr,
    output logic                 o_pwrite,
    output logic [31:0]          o_pwdata,
    output logic [2:0]           o_pprot,
    output logic [3:0]           o_pstrb,
    input  logic [NSLV*32-1:0]   i_prdata,
    input  logic [NSLV-1:0]      i_pready,
    input  logic [NSLV-1:0]      i_pslverr,
    output logic                 o_irq_tmo
);

    localparam int         TO_W        = $clog2(TIMEOUT + 2);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;
    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    typedef enum logic [2:0] {S_IDLE, S_WDAT, S_SETUP, S_ACCESS, S_BRESP, S_RDAT} state_t;

    function automatic logic f_miss(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] off;
        off = a - BASE_ADDR;
        return (a < BASE_ADDR) || ((off >> SLV_AW) >= ADDR_W'(NSLV));
    endfunction

    // Reserved burst type and non-power-of-two WRAP lengths fall back to INCR.
    function automatic logic [1:0] f_burst(input logic [1:0] b, input logic [3:0] len);
        f_burst = b;
        if (b == 2'b11)
            f_burst = BURST_INCR;
        else if (b == BURST_WRAP &&
                 !(len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15))
            f_burst = BURST_INCR;
    endfunction

    state_t              r_state, w_nxt_state;
    logic                r_run;
    logic                r_prio_wr;
    logic                r_is_wr;
    logic [ID_W-1:0]     r_id;
    logic [ADDR_W-1:0]   r_addr;
    logic [3:0]          r_len;
    logic [1:0]          r_burst;
    logic [2:0]          r_prot;
    logic [3:0]          r_cnt;
    logic [1:0]          r_resp;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic [TO_W-1:0]     r_tmo;
    logic                r_irq;

    logic                w_grant_w, w_grant_r;
    logic                w_cur_miss, w_ar_miss, w_nxt_miss;
    logic                w_last;
    logic [ADDR_W-1:0]   w_nxt_addr, w_incr, w_wrap_mask, w_off;
    logic [3:0]          w_slv;
    logic [NSLV-1:0]     w_psel_oh;
    logic                w_sel_rdy, w_sel_err;
    logic [31:0]         w_sel_rdata;
    logic                w_tmo, w_acc_done;
    logic [1:0]          w_beat_resp;
    logic                w_unused;

    assign w_unused = i_peri_wlast;

    // r_run keeps both readys low until the first clock after reset release.
    assign w_grant_w = r_run && (r_state == S_IDLE) && i_peri_awvalid &&
                       (!i_peri_arvalid || r_prio_wr);
    assign w_grant_r = r_run && (r_state == S_IDLE) && i_peri_arvalid && !w_grant_w;

    assign w_cur_miss  = f_miss(r_addr);
    assign w_ar_miss   = f_miss(i_peri_araddr);
    assign w_nxt_miss  = f_miss(w_nxt_addr);
    assign w_last      = (r_cnt == r_len);

    assign w_incr      = r_addr + ADDR_W'(4);
    assign w_wrap_mask = ADDR_W'({r_len, 2'b11});

    always_comb begin
        w_nxt_addr = w_incr;
        case (r_burst)
            BURST_FIXED: w_nxt_addr = r_addr;
            BURST_WRAP:  w_nxt_addr = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
            default:     w_nxt_addr = w_incr;
        endcase
    end

    assign w_off = r_addr - BASE_ADDR;
    assign w_slv = 4'(w_off >> SLV_AW);

    always_comb begin
        w_psel_oh   = '0;
        w_sel_rdy   = 1'b0;
        w_sel_err   = 1'b0;
        w_sel_rdata = '0;
        for (int k = 0; k < NSLV; k++) begin
            if (w_slv == 4'(k)) begin
                w_psel_oh[k] = 1'b1;
                w_sel_rdy    = i_pready[k];
                w_sel_err    = i_pslverr[k];
                w_sel_rdata  = i_prdata[32*k +: 32];
            end
        end
    end

    assign w_tmo       = (TIMEOUT != 0) && (r_state == S_ACCESS) && !w_sel_rdy &&
                         (r_tmo == TO_W'(TIMEOUT - 1));
    assign w_acc_done  = (r_state == S_ACCESS) && (w_sel_rdy || w_tmo);
    assign w_beat_resp = (w_tmo || w_sel_err) ? RESP_SLVERR : RESP_OKAY;

    always_comb begin
        w_nxt_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant_w)
                    w_nxt_state = S_WDAT;
                else if (w_grant_r)
                    w_nxt_state = w_ar_miss ? S_RDAT : S_SETUP;
            end
            S_WDAT: begin
                if (i_peri_wvalid) begin
                    if (!w_cur_miss)
                        w_nxt_state = S_SETUP;
                    else
                        w_nxt_state = w_last ? S_BRESP : S_WDAT;
                end
            end
            S_SETUP:  w_nxt_state = S_ACCESS;
            S_ACCESS: begin
                if (w_acc_done) begin
                    if (r_is_wr)
                        w_nxt_state = w_last ? S_BRESP : S_WDAT;
                    else
                        w_nxt_state = S_RDAT;
                end
            end
            S_BRESP: if (i_peri_bready) w_nxt_state = S_IDLE;
            S_RDAT: begin
                if (i_peri_rready) begin
                    if (w_last)
                        w_nxt_state = S_IDLE;
                    else
                        w_nxt_state = w_nxt_miss ? S_RDAT : S_SETUP;
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // Writes advance count/address at beat end; reads advance when R handshakes.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_state   <= S_IDLE;
            r_run     <= 1'b0;
            r_prio_wr <= 1'b1;
            r_is_wr   <= 1'b0;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_burst   <= '0;
            r_prot    <= '0;
            r_cnt     <= '0;
            r_resp    <= RESP_OKAY;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
            r_tmo     <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_state <= w_nxt_state;
            r_run   <= 1'b1;
            r_irq   <= w_tmo;
            if (w_grant_w || w_grant_r) begin
                r_prio_wr <= ~r_prio_wr;
                r_is_wr   <= w_grant_w;
                r_id      <= w_grant_w ? i_peri_awid    : i_peri_arid;
                r_addr    <= w_grant_w ? i_peri_awaddr  : i_peri_araddr;
                r_len     <= w_grant_w ? i_peri_awlen   : i_peri_arlen;
                r_burst   <= w_grant_w ? f_burst(i_peri_awburst, i_peri_awlen)
                                       : f_burst(i_peri_arburst, i_peri_arlen);
                r_prot    <= w_grant_w ? i_peri_awprot  : i_peri_arprot;
                r_cnt     <= '0;
                r_resp    <= RESP_OKAY;
                r_rdata   <= '0;
                r_rresp   <= (w_grant_r && w_ar_miss) ? RESP_DECERR : RESP_OKAY;
            end
            case (r_state)
                S_WDAT: begin
                    if (i_peri_wvalid) begin
                        r_wdata <= i_peri_wdata;
                        r_wstrb <= i_peri_wstrb;
                        if (w_cur_miss) begin
                            r_resp <= RESP_DECERR;
                            r_cnt  <= r_cnt + 4'd1;
                            r_addr <= w_nxt_addr;
                        end
                    end
                end
                S_SETUP: r_tmo <= '0;
                S_ACCESS: begin
                    if (TIMEOUT != 0)
                        r_tmo <= r_tmo + TO_W'(1);
                    if (w_acc_done) begin
                        if (r_is_wr) begin
                            if (w_beat_resp > r_resp)
                                r_resp <= w_beat_resp;
                            r_cnt  <= r_cnt + 4'd1;
                            r_addr <= w_nxt_addr;
                        end else begin
                            r_rdata <= w_tmo ? '0 : w_sel_rdata;
                            r_rresp <= w_beat_resp;
                        end
                    end
                end
                S_RDAT: begin
                    if (i_peri_rready && !w_last) begin
                        r_cnt  <= r_cnt + 4'd1;
                        r_addr <= w_nxt_addr;
                        if (w_nxt_miss) begin
                            r_rdata <= '0;
                            r_rresp <= RESP_DECERR;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_peri_awready = w_grant_w;
    assign o_peri_arready = w_grant_r;
    assign o_peri_wready  = (r_state == S_WDAT);
    assign o_peri_bvalid  = (r_state == S_BRESP);
    assign o_peri_bid     = r_id;
    assign o_peri_bresp   = r_resp;
    assign o_peri_rvalid  = (r_state == S_RDAT);
    assign o_peri_rid     = r_id;
    assign o_peri_rdata   = r_rdata;
    assign o_peri_rresp   = r_rresp;
    assign o_peri_rlast   = (r_state == S_RDAT) && w_last;
    assign o_psel         = (r_state == S_SETUP || r_state == S_ACCESS) ? w_psel_oh : '0;
    assign o_penable      = (r_state == S_ACCESS);
    assign o_paddr        = {r_addr[ADDR_W-1:2], 2'b00};
    assign o_pwrite       = r_is_wr;
    assign o_pwdata       = r_wdata;
    assign o_pprot        = r_prot;
    assign o_pstrb        = r_is_wr ? r_wstrb : 4'h0;
    assign o_irq_tmo      = r_irq;

endmodule
